mem_bus_monitor: RTL and testbench
==================================

MEM_BUS_MONITOR -- requirements
Module: mem_bus_monitor

Interface
REQ-001 SHALL have parameter DONE_ADDR, default 32'h0000_0010, completion address.
REQ-002 SHALL have parameter STALL_LIMIT, default 16, consecutive stall cycles that count as a fault (>=2).
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000, maximum RUN cycles before fault.
REQ-004 SHALL have parameter TRACE_DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  pulse that begins (or restarts) a run.
REQ-009 SHALL have ports mem_valid, mem_ready  input  1 each  core native bus handshake.
REQ-010 SHALL have ports mem_addr, mem_wdata, mem_rdata  input  32 each, and mem_wstrb  input  4.
REQ-011 SHALL have port trap  input  1  core trap indication.
REQ-012 SHALL have port state  output  2  IDLE=0, RUN=1, PASS=2, FAIL=3.
REQ-013 SHALL have ports cycle_count  output  CNT_W, and done_value  output  32.
REQ-014 SHALL have port status  output  3  {stall_err, timeout_err, trap_seen}.
REQ-015 SHALL have ports trc_rd  input  1 (pop), trc_valid  output  1, trc_data  output  65 {we, addr[31:0], data[31:0]}, trc_overflow  output  1.

Function
REQ-016 SHALL define a transaction as mem_valid & mem_ready sampled on a rising edge; a write when |mem_wstrb, else a read.
REQ-017 SHALL transition IDLE->RUN on start; start in PASS/FAIL SHALL also enter RUN; start in RUN SHALL restart RUN.
REQ-018 SHALL, on entering RUN, clear cycle_count, done_value, status, stall counter, trace FIFO and trc_overflow in the same edge.
REQ-019 SHALL increment cycle_count by 1 every RUN cycle including the terminating cycle, saturating at all-ones; frozen outside RUN.
REQ-020 SHALL go RUN->PASS on a write transaction with mem_addr==DONE_ADDR, latching mem_wdata into done_value.
REQ-021 SHALL go RUN->FAIL with trap_seen=1 when trap=1 in RUN.
REQ-022 SHALL count consecutive RUN cycles with mem_valid & !mem_ready, reset the count on any other cycle, and go RUN->FAIL with stall_err=1 in the cycle the count reaches STALL_LIMIT.
REQ-023 SHALL go RUN->FAIL with timeout_err=1 in the cycle cycle_count would reach TIMEOUT (i.e. the TIMEOUT-th RUN cycle) without prior termination.
REQ-024 SHALL resolve simultaneous events by priority completion > trap > stall > timeout for the state; every active condition SHALL still set its status bit.
REQ-025 SHALL keep PASS and FAIL sticky, with outputs frozen, until start or reset.
REQ-026 SHALL push every RUN transaction (including the completion write) into the trace FIFO as {write, mem_addr, write ? mem_wdata : mem_rdata}.
REQ-027 SHALL present the FIFO head on trc_data with trc_valid=1 whenever non-empty (first-word fall-through); trc_rd pops when trc_valid.
REQ-028 SHALL ignore trc_rd when empty; trc_data is don't-care when trc_valid=0.
REQ-029 SHALL, when full, drop a push and set trc_overflow sticky, unless trc_rd pops in the same cycle, in which case both occur and no overflow is flagged.
REQ-030 SHALL allow pops in IDLE/PASS/FAIL; pushes occur only in RUN.

Reset
REQ-031 SHALL, while resetn=0, force state=IDLE, cycle_count=0, done_value=0, status=0, trc_valid=0, trc_overflow=0, FIFO empty, stall count 0, regardless of clk.
REQ-032 SHALL abandon any run in progress on reset assertion and remain in IDLE after deassertion until start.

Verification
REQ-033 start, 5 reads then write 0xCAFE_0001 to 0x10 on cycle 7 -> PASS, done_value=0xCAFE_0001, cycle_count=7, trace holds 6 entries in order.
REQ-034 STALL_LIMIT=4, mem_valid=1 and mem_ready=0 for 4 cycles -> FAIL, status=3'b100; with 3 stalls then ready -> stays RUN.
REQ-035 TIMEOUT=20, no completion -> FAIL on 20th RUN cycle, cycle_count=20, status=3'b010.
REQ-036 trap=1 together with completion write -> PASS, status=3'b001, done_value latched.
REQ-037 TRACE_DEPTH=4, 6 transactions without pops -> 4 entries kept, trc_overflow=1; push+pop when full -> count unchanged, no overflow.
REQ-038 resetn low mid-RUN with 3 entries queued -> IDLE, all outputs 0, trc_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mem_bus_monitor.sv
// Watches a core's native memory bus and judges a run as PASS or FAIL.
// Runs end on a completion write, a trap, a stall or a timeout. Bus transactions made during a run are kept in a trace FIFO.
module mem_bus_monitor #(
  parameter logic [31:0] DONE_ADDR   = 32'h0000_0010,
  parameter int          STALL_LIMIT = 16,
  parameter int          TIMEOUT     = 1_000_000,
  parameter int          TRACE_DEPTH = 8,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mem_valid,
  input  logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic [3:0]       mem_wstrb,
  input  logic             trap,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      done_value,
  output logic [2:0]       status,
  input  logic             trc_rd,
  output logic             trc_valid,
  output logic [64:0]      trc_data,
  output logic             trc_overflow
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stall_cnt, stall_next;
  logic          in_run, txn, is_write;
  logic          done_hit, stall_hit, timeout_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    in_run      = (state_q == RUN);
    txn         = mem_valid & mem_ready;
    is_write    = |mem_wstrb;
    done_hit    = in_run & txn & is_write & (mem_addr == DONE_ADDR);
    stall_next  = (mem_valid & ~mem_ready) ? stall_cnt + 1'b1 : '0;
    stall_hit   = in_run & (stall_next == SW'(STALL_LIMIT));
    timeout_hit = in_run & (cycle_count == CNT_W'(TIMEOUT - 1));
    if (start) begin
      state_d = RUN;
    end else if (in_run) begin
      if (done_hit)                            state_d = PASS;
      else if (trap | stall_hit | timeout_hit) state_d = FAIL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_count <= '0;
      done_value  <= '0;
      status      <= '0;
      stall_cnt   <= '0;
    end else if (start) begin
      cycle_count <= '0;
      done_value  <= '0;
      status      <= '0;
      stall_cnt   <= '0;
    end else if (in_run) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      stall_cnt <= stall_next;
      if (done_hit) done_value <= mem_wdata;
      // Completion may win the state, but every event still leaves its status bit set.
      status <= status | {stall_hit, timeout_hit, trap};
    end
  end

  // Trace FIFO. It only pushes during a run and can pop in any state.
  logic [64:0]   trc_mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic          push, pop, full, push_ok;

  assign push    = in_run & ~start & txn;
  assign pop     = trc_rd & trc_valid;
  assign full    = (fill == (AW + 1)'(TRACE_DEPTH));
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      trc_overflow <= 1'b0;
    end else if (start) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      trc_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      if (push & full & ~pop) trc_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness comes from the fill count alone.
  always_ff @(posedge clk) begin
    if (push_ok) trc_mem[wr_ptr] <= {is_write, mem_addr, is_write ? mem_wdata : mem_rdata};
  end

  assign trc_valid = (fill != '0);
  assign trc_data  = trc_mem[rd_ptr];

endmodule

// File: tb/tb_mem_bus_monitor.sv
// Scoreboard bench for mem_bus_monitor. Two instances share the bus stimulus.
// One instance has an 8-entry trace and the other has a 4-entry trace, so overflow is exercised on the second.
module tb_mem_bus_monitor;

  localparam logic [31:0] DONE = 32'h0000_0010;

  logic        clk = 1'b0, resetn = 1'b1, start = 1'b0, trap = 1'b0;
  logic        mem_valid = 1'b0, mem_ready = 1'b0, trc_rd = 1'b0, trc_rd4 = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
  logic [3:0]  mem_wstrb = '0;

  logic [1:0]  state, state4;
  logic [31:0] cycle_count, cycle_count4, done_value, done_value4;
  logic [2:0]  status, status4;
  logic        trc_valid, trc_valid4, trc_overflow, trc_overflow4;
  logic [64:0] trc_data, trc_data4;

  int passed = 0, total = 0;
  logic [64:0] exp8_q[$], exp4_q[$];
  logic ovf8_m = 1'b0, ovf4_m = 1'b0;

  mem_bus_monitor #(.STALL_LIMIT(4), .TIMEOUT(20), .TRACE_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wstrb(mem_wstrb),
    .trap(trap), .state(state), .cycle_count(cycle_count), .done_value(done_value),
    .status(status), .trc_rd(trc_rd), .trc_valid(trc_valid), .trc_data(trc_data),
    .trc_overflow(trc_overflow));

  mem_bus_monitor #(.STALL_LIMIT(4), .TIMEOUT(20), .TRACE_DEPTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .start(start), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wstrb(mem_wstrb),
    .trap(trap), .state(state4), .cycle_count(cycle_count4), .done_value(done_value4),
    .status(status4), .trc_rd(trc_rd4), .trc_valid(trc_valid4), .trc_data(trc_data4),
    .trc_overflow(trc_overflow4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_off();
    mem_valid = 1'b0;
    mem_ready = 1'b0;
    mem_wstrb = 4'h0;
    trap      = 1'b0;
  endtask

  // One bus transaction in RUN. The expected trace entries are queued for both FIFO models.
  task automatic bus_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic pop4);
    logic [64:0] e;
    e = {we, addr, data};
    mem_valid = 1'b1;
    mem_ready = 1'b1;
    mem_wstrb = we ? 4'hF : 4'h0;
    mem_addr  = addr;
    mem_wdata = we ? data : $urandom;
    mem_rdata = we ? $urandom : data;
    if (exp8_q.size() < 8) exp8_q.push_back(e);
    else                   ovf8_m = 1'b1;
    trc_rd4 = pop4;
    if (pop4 && exp4_q.size() > 0) begin
      total++;
      if (trc_valid4 !== 1'b1 || trc_data4 !== exp4_q[0])
        $display("FAIL pop4_head: got valid=%b data=%h, want %h", trc_valid4, trc_data4, exp4_q[0]);
      else passed++;
      void'(exp4_q.pop_front());
    end
    if (exp4_q.size() < 4) exp4_q.push_back(e);
    else                   ovf4_m = 1'b1;
    tick();
    bus_off();
    trc_rd4 = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp8_q.delete();
    exp4_q.delete();
    ovf8_m = 1'b0;
    ovf4_m = 1'b0;
    total++;
    if ({state, cycle_count, done_value, status, trc_valid, trc_overflow} !== {2'd1, 32'd0, 32'd0, 3'd0, 2'b00})
      $display("FAIL start_clear: got state=%0d cnt=%0d done=%h st=%b v=%b ovf=%b, want RUN and zeros",
               state, cycle_count, done_value, status, trc_valid, trc_overflow);
    else passed++;
  endtask

  task automatic drain();
    while (exp8_q.size() > 0) begin
      total++;
      if (trc_valid !== 1'b1 || trc_data !== exp8_q[0])
        $display("FAIL trace8: got valid=%b data=%h, want %h", trc_valid, trc_data, exp8_q[0]);
      else passed++;
      void'(exp8_q.pop_front());
      trc_rd = 1'b1;
      tick();
      trc_rd = 1'b0;
    end
    total++;
    if (trc_valid !== 1'b0 || trc_overflow !== ovf8_m)
      $display("FAIL trace8_end: got valid=%b ovf=%b, want valid=0 ovf=%b", trc_valid, trc_overflow, ovf8_m);
    else passed++;
    while (exp4_q.size() > 0) begin
      total++;
      if (trc_valid4 !== 1'b1 || trc_data4 !== exp4_q[0])
        $display("FAIL trace4: got valid=%b data=%h, want %h", trc_valid4, trc_data4, exp4_q[0]);
      else passed++;
      void'(exp4_q.pop_front());
      trc_rd4 = 1'b1;
      tick();
      trc_rd4 = 1'b0;
    end
    total++;
    if (trc_valid4 !== 1'b0 || trc_overflow4 !== ovf4_m)
      $display("FAIL trace4_end: got valid=%b ovf=%b, want valid=0 ovf=%b", trc_valid4, trc_overflow4, ovf4_m);
    else passed++;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({state, cycle_count, done_value, status, trc_valid, trc_overflow,
         state4, cycle_count4, done_value4, status4, trc_valid4, trc_overflow4} !== '0)
      $display("FAIL reset_values: got state=%0d cnt=%0d st=%b v=%b, want all zero", state, cycle_count, status, trc_valid);
    else passed++;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    total++;
    if (state !== 2'd0 || cycle_count !== 32'd0)
      $display("FAIL reset_idle: got state=%0d cnt=%0d, want 0 0", state, cycle_count);
    else passed++;
  endtask

  task automatic test_pass();
    do_start();
    for (int i = 0; i < 5; i++) bus_txn(1'b0, 32'h100 + 32'(4 * i), $urandom, 1'b0);
    tick();
    bus_txn(1'b1, DONE, 32'hCAFE_0001, 1'b0);
    total++;
    if (state !== 2'd2) $display("FAIL pass_state: got %0d, want 2", state); else passed++;
    total++;
    if (done_value !== 32'hCAFE_0001) $display("FAIL pass_done: got %h, want cafe0001", done_value); else passed++;
    total++;
    if (cycle_count !== 32'd7) $display("FAIL pass_cycles: got %0d, want 7", cycle_count); else passed++;
    total++;
    if (status !== 3'b000) $display("FAIL pass_status: got %b, want 000", status); else passed++;
    total++;
    if (trc_overflow4 !== 1'b1) $display("FAIL ovf4_set: got %b, want 1", trc_overflow4); else passed++;
    mem_valid = 1'b1; mem_ready = 1'b1; mem_wstrb = 4'hF; mem_addr = DONE; mem_wdata = 32'hDEAD_BEEF;
    tick();
    bus_off();
    total++;
    if ({state, cycle_count, done_value} !== {2'd2, 32'd7, 32'hCAFE_0001})
      $display("FAIL pass_frozen: got state=%0d cnt=%0d done=%h, want 2 7 cafe0001", state, cycle_count, done_value);
    else passed++;
    drain();
  endtask

  task automatic test_stall();
    do_start();
    mem_valid = 1'b1; mem_ready = 1'b0;
    repeat (3) tick();
    bus_txn(1'b0, 32'h200, 32'h0BAD_F00D, 1'b0);
    total++;
    if (state !== 2'd1) $display("FAIL stall3_run: got %0d, want 1", state); else passed++;
    mem_valid = 1'b1; mem_ready = 1'b0;
    repeat (3) tick();
    total++;
    if (state !== 2'd1) $display("FAIL stall_pre: got %0d, want 1", state); else passed++;
    tick();
    bus_off();
    total++;
    if ({state, status, cycle_count} !== {2'd3, 3'b100, 32'd8})
      $display("FAIL stall_fail: got state=%0d st=%b cnt=%0d, want 3 100 8", state, status, cycle_count);
    else passed++;
    drain();
  endtask

  task automatic test_timeout();
    do_start();
    repeat (19) tick();
    total++;
    if (state !== 2'd1 || cycle_count !== 32'd19)
      $display("FAIL timeout_pre: got state=%0d cnt=%0d, want 1 19", state, cycle_count);
    else passed++;
    tick();
    total++;
    if ({state, status, cycle_count} !== {2'd3, 3'b010, 32'd20})
      $display("FAIL timeout_fail: got state=%0d st=%b cnt=%0d, want 3 010 20", state, status, cycle_count);
    else passed++;
    tick();
    total++;
    if (cycle_count !== 32'd20) $display("FAIL timeout_frozen: got %0d, want 20", cycle_count); else passed++;
    drain();
  endtask

  task automatic test_trap_done();
    do_start();
    bus_txn(1'b0, 32'h300, 32'h1111_2222, 1'b0);
    trap = 1'b1;
    bus_txn(1'b1, DONE, 32'h1234_5678, 1'b0);
    total++;
    if ({state, status, done_value} !== {2'd2, 3'b001, 32'h1234_5678})
      $display("FAIL trap_done: got state=%0d st=%b done=%h, want 2 001 12345678", state, status, done_value);
    else passed++;
    drain();
  endtask

  task automatic test_fifo_full();
    do_start();
    for (int i = 0; i < 4; i++) bus_txn(1'b0, 32'h400 + 32'(4 * i), $urandom, 1'b0);
    total++;
    if (trc_valid4 !== 1'b1 || trc_overflow4 !== 1'b0)
      $display("FAIL full4: got valid=%b ovf=%b, want 1 0", trc_valid4, trc_overflow4);
    else passed++;
    bus_txn(1'b1, 32'h500, 32'h5555_AAAA, 1'b1);
    total++;
    if (trc_overflow4 !== 1'b0) $display("FAIL pushpop_ovf: got %b, want 0", trc_overflow4); else passed++;
    bus_txn(1'b1, DONE, 32'h0000_0042, 1'b1);
    total++;
    if (state !== 2'd2 || trc_overflow4 !== 1'b0)
      $display("FAIL pushpop_done: got state=%0d ovf=%b, want 2 0", state, trc_overflow4);
    else passed++;
    drain();
  endtask

  task automatic test_restart_trap();
    do_start();
    repeat (3) tick();
    total++;
    if (cycle_count !== 32'd3) $display("FAIL run_cycles: got %0d, want 3", cycle_count); else passed++;
    do_start();
    bus_txn(1'b0, 32'h600, 32'h6666_0000, 1'b0);
    trap = 1'b1;
    tick();
    bus_off();
    total++;
    if ({state, status, cycle_count} !== {2'd3, 3'b001, 32'd2})
      $display("FAIL trap_fail: got state=%0d st=%b cnt=%0d, want 3 001 2", state, status, cycle_count);
    else passed++;
    drain();
  endtask

  task automatic test_reset_midrun();
    do_start();
    for (int i = 0; i < 3; i++) bus_txn(1'b0, 32'h700 + 32'(4 * i), $urandom, 1'b0);
    total++;
    if (trc_valid !== 1'b1) $display("FAIL midrun_queued: got %b, want 1", trc_valid); else passed++;
    #3 resetn = 1'b0;
    #1;
    total++;
    if ({state, cycle_count, done_value, status, trc_valid, trc_overflow} !== '0)
      $display("FAIL midrun_reset: got state=%0d cnt=%0d st=%b v=%b, want all zero", state, cycle_count, status, trc_valid);
    else passed++;
    exp8_q.delete();
    exp4_q.delete();
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    total++;
    if ({state, cycle_count, trc_valid} !== {2'd0, 32'd0, 1'b0})
      $display("FAIL midrun_idle: got state=%0d cnt=%0d v=%b, want 0 0 0", state, cycle_count, trc_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_stall();
    test_timeout();
    test_trap_done();
    test_fifo_full();
    test_restart_trap();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
